life_gen_sequencer: RTL and testbench
=====================================

Name: life_gen_sequencer

Overview:
Sequences one generation of the Game of Life array through a row-parallel bank of HEIGHT shredder cells, repeated for a requested number of generations. Streams frame columns from a dual-port cell memory into the bank, clears the bank shift registers between generations, and writes each computed column back in place. Sits between the host/control register block and the shredder bank plus frame memory.

Parameters:
WIDTH, 8, columns per frame (≥3)
HEIGHT, 8, rows per frame = shredders in bank = memory word width
AW, 3, column address width, ≥ clog2(WIDTH)
GEN_W, 16, width of generation counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  pulse; begin run when idle
gen_count  in  GEN_W  generations to compute, sampled with start
abort  in  1  stop run at next edge
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion, including abort
gen_done_cnt  out  GEN_W  generations fully written this run
mem_rd_en  out  1  column read strobe
mem_rd_addr  out  AW  column read address
mem_rd_data  in  HEIGHT  column data, valid cycle after mem_rd_en
mem_wr_en  out  1  column write strobe
mem_wr_addr  out  AW  column write address
mem_wr_data  out  HEIGHT  next-generation column
bank_clr  out  1  active-high clear to all shredder shift registers
bank_din  out  HEIGHT  din to shredder row i = bit i
bank_next  in  HEIGHT  next_state from shredder row i = bit i

Behaviour:
- Reset (rst=0 at edge): state IDLE; busy=0, done=0, gen_done_cnt=0, mem_rd_en=0, mem_wr_en=0, bank_clr=0, bank_din=0, addresses=0.
- Memory is simple dual-port, 1-cycle read latency. Read and write can occur in the same cycle to different addresses.
- Shredders shift every clock, so the stream must be gapless. bank_din=0 whenever no read data is being streamed.
- States: IDLE, CLR, STREAM, DONE.
- IDLE: when start=1 and gen_count≠0, latch gen_count, clear gen_done_cnt, go to CLR. When start=1 and gen_count=0, go to DONE with no memory access. start is ignored outside IDLE.
- Per generation, cycle 0 = CLR, cycles 1..WIDTH+2 = STREAM. Generation length is WIDTH+3 cycles.
  - Cycle 0: bank_clr=1, mem_rd_en=1, rd_addr=0.
  - Cycle k, 1≤k≤WIDTH: bank_din=mem_rd_data (column k-1). Issue read of column k while k<WIDTH.
  - Cycle WIDTH+1: bank_din=0, the right-edge flush. The left edge is zero through bank_clr.
  - Cycle j, 3≤j≤WIDTH+2: mem_wr_en=1, wr_addr=j-3, wr_data=bank_next combinationally.
- In-place write is safe: column j-3 is always already read when it is written.
- After the last write, gen_done_cnt increments. If gen_done_cnt now equals the latched count, go to DONE; otherwise go to CLR on the next cycle with no idle gap.
- busy=1 in CLR and STREAM.
- DONE lasts one cycle with done=1, then returns to IDLE. gen_done_cnt holds its value until the next accepted start.
- abort=1 in CLR or STREAM: at the next edge, all strobes drop and the state goes to DONE. gen_done_cnt counts only completed generations, and frame memory may hold a partial generation. Abort in IDLE or DONE has no effect.
- Mid-run reset: immediate return to reset values and no further strobes. Memory contents are undefined.
- Top and bottom row boundary (nsum inputs = 0) is bank wiring and is outside this block.

Test Plan:
- Reset/idle: rst=0 for 2 cycles with start=1 -> all outputs 0. After release, with start=0 for 10 cycles -> no strobes.
- Timing, WIDTH=8, gen_count=1, start at cycle 0:
  - bank_clr at cycle 1.
  - rd_en cycles 1–8, addresses 0–7.
  - wr_en cycles 4–11, addresses 0–7.
  - done at cycle 12, gen_done_cnt=1, busy cycles 1–11.
- Blinker: column 2 = 8'b00001110, others 0, gen_count=1 -> columns 1, 2, 3 = 8'b00000100, others 0. With gen_count=2 -> original frame restored.
- Back-to-back generations: gen_count=3 -> bank_clr pulses exactly 11 cycles apart, no gap cycle, done once, gen_done_cnt=3.
- Edge/zero cases:
  - gen_count=0 -> done the cycle after start, no rd_en/wr_en.
  - start while busy is ignored.
  - Glider touching column 0 and column 7 -> no wrap-around; matches a zero-padded reference model.
- Abort/reset mid-run: abort at cycle 6 of generation 2 with gen_count=5 -> strobes stop next cycle, done pulse, gen_done_cnt=1. rst=0 mid-stream -> reset values the next cycle.

Source files
------------

// File: rtl/life_gen_sequencer.sv
// Streams frame columns from cell memory through a row-parallel shredder bank,
// one generation per WIDTH+3 cycles, writing each next-state column back in place.
module life_gen_sequencer #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int AW     = 3,
    parameter int GEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [GEN_W-1:0]  gen_count_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [GEN_W-1:0]  gen_done_cnt_o,
    output logic              mem_rd_en_o,
    output logic [AW-1:0]     mem_rd_addr_o,
    input  logic [HEIGHT-1:0] mem_rd_data_i,
    output logic              mem_wr_en_o,
    output logic [AW-1:0]     mem_wr_addr_o,
    output logic [HEIGHT-1:0] mem_wr_data_o,
    output logic              bank_clr_o,
    output logic [HEIGHT-1:0] bank_din_o,
    input  logic [HEIGHT-1:0] bank_next_i
);

    localparam int GEN_LEN = WIDTH + 3;
    localparam int PW      = $clog2(GEN_LEN);

    localparam logic [PW-1:0] FIRST_DIN  = PW'(1);
    localparam logic [PW-1:0] LAST_DIN   = PW'(WIDTH);
    localparam logic [PW-1:0] FIRST_WR   = PW'(3);
    localparam logic [PW-1:0] LAST_PHASE = PW'(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, CLR, STREAM, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [GEN_W-1:0]  genTarget_q, genTarget_d;
    logic [GEN_W-1:0]  genDoneCnt_q, genDoneCnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bankClr_q, bankClr_d;
    logic              rdEn_q, rdEn_d;
    logic [AW-1:0]     rdAddr_q, rdAddr_d;
    logic              wrEn_q, wrEn_d;
    logic [AW-1:0]     wrAddr_q, wrAddr_d;
    logic              streamEn_q, streamEn_d;
    logic              inRun;

    // Next state, then every strobe is derived from the phase it will be in,
    // so all outputs come straight from registers.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        genTarget_d  = genTarget_q;
        genDoneCnt_d = genDoneCnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    genDoneCnt_d = '0;
                    if (gen_count_i != '0) begin
                        genTarget_d = gen_count_i;
                        state_d     = CLR;
                        phase_d     = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLR, STREAM: begin
                // The final write happens during the last phase, so that
                // generation counts as complete even if abort arrives with it.
                if (phase_q == LAST_PHASE) begin
                    genDoneCnt_d = genDoneCnt_q + 1'b1;
                end
                if (abort_i) begin
                    state_d = DONE;
                end else if (phase_q == LAST_PHASE) begin
                    if (genDoneCnt_d == genTarget_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLR;
                        phase_d = '0;
                    end
                end else begin
                    state_d = STREAM;
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inRun      = (state_d == CLR) || (state_d == STREAM);
        busy_d     = inRun;
        done_d     = (state_d == DONE);
        bankClr_d  = (state_d == CLR);
        rdEn_d     = inRun && (phase_d < LAST_DIN);
        rdAddr_d   = rdEn_d ? AW'(phase_d) : '0;
        streamEn_d = inRun && (phase_d >= FIRST_DIN) && (phase_d <= LAST_DIN);
        wrEn_d     = inRun && (phase_d >= FIRST_WR);
        wrAddr_d   = wrEn_d ? AW'(phase_d - FIRST_WR) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            genTarget_q  <= '0;
            genDoneCnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bankClr_q    <= 1'b0;
            rdEn_q       <= 1'b0;
            rdAddr_q     <= '0;
            wrEn_q       <= 1'b0;
            wrAddr_q     <= '0;
            streamEn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            genTarget_q  <= genTarget_d;
            genDoneCnt_q <= genDoneCnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bankClr_q    <= bankClr_d;
            rdEn_q       <= rdEn_d;
            rdAddr_q     <= rdAddr_d;
            wrEn_q       <= wrEn_d;
            wrAddr_q     <= wrAddr_d;
            streamEn_q   <= streamEn_d;
        end
    end

    // Read data and bank results pass through unregistered to keep the stream gapless.
    assign bank_din_o     = streamEn_q ? mem_rd_data_i : '0;
    assign mem_wr_data_o  = wrEn_q ? bank_next_i : '0;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign gen_done_cnt_o = genDoneCnt_q;
    assign mem_rd_en_o    = rdEn_q;
    assign mem_rd_addr_o  = rdAddr_q;
    assign mem_wr_en_o    = wrEn_q;
    assign mem_wr_addr_o  = wrAddr_q;
    assign bank_clr_o     = bankClr_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: frame memory and shredder bank models around the DUT,
// a cycle-timeline model checked every cycle, and a 2D Life reference for frame results.
module tb_life_gen_sequencer;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam int AW     = 3;
    localparam int GEN_W  = 16;
    localparam int GL     = WIDTH + 3;
    localparam int MAXC   = 200;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic [GEN_W-1:0]  genCount;
    logic              abort;
    logic              busy;
    logic              done;
    logic [GEN_W-1:0]  genDoneCnt;
    logic              memRdEn;
    logic [AW-1:0]     memRdAddr;
    logic [HEIGHT-1:0] memRdData = '0;
    logic              memWrEn;
    logic [AW-1:0]     memWrAddr;
    logic [HEIGHT-1:0] memWrData;
    logic              bankClr;
    logic [HEIGHT-1:0] bankDin;
    logic [HEIGHT-1:0] bankNext;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    life_gen_sequencer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW), .GEN_W(GEN_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .gen_count_i    (genCount),
        .abort_i        (abort),
        .busy_o         (busy),
        .done_o         (done),
        .gen_done_cnt_o (genDoneCnt),
        .mem_rd_en_o    (memRdEn),
        .mem_rd_addr_o  (memRdAddr),
        .mem_rd_data_i  (memRdData),
        .mem_wr_en_o    (memWrEn),
        .mem_wr_addr_o  (memWrAddr),
        .mem_wr_data_o  (memWrData),
        .bank_clr_o     (bankClr),
        .bank_din_o     (bankDin),
        .bank_next_i    (bankNext)
    );

    // Simple dual-port frame memory with one cycle of read latency.
    logic [HEIGHT-1:0] mem [WIDTH];
    always @(posedge clk) begin
        if (memRdEn) memRdData <= mem[memRdAddr];
        if (memWrEn) mem[memWrAddr] <= memWrData;
    end

    // Shredder bank: a three-column window per row; next state of the centre column.
    logic [HEIGHT-1:0] srR = '0, srC = '0, srL = '0;
    always @(posedge clk) begin
        if (bankClr) begin
            srR <= '0; srC <= '0; srL <= '0;
        end else begin
            srR <= bankDin; srC <= srR; srL <= srC;
        end
    end

    function automatic logic [HEIGHT-1:0] lifeColumn(input logic [HEIGHT-1:0] l,
                                                     input logic [HEIGHT-1:0] c,
                                                     input logic [HEIGHT-1:0] r);
        logic [HEIGHT-1:0] res;
        res = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            int n;
            n = 0;
            for (int d = -1; d <= 1; d++) begin
                if (i + d >= 0 && i + d < HEIGHT) begin
                    n += int'(l[i+d]) + int'(r[i+d]);
                    if (d != 0) n += int'(c[i+d]);
                end
            end
            res[i] = c[i] ? (n == 2 || n == 3) : (n == 3);
        end
        return res;
    endfunction

    assign bankNext = lifeColumn(srL, srC, srR);

    // Run timeline model: position within the run gives every expected strobe.
    bit mActive = 1'b0;
    bit mDone   = 1'b0;
    int mCycle  = 0;
    int mTarget = 0;
    int mGen    = 0;

    always @(posedge clk) begin
        if (!rstN) begin
            mActive <= 1'b0; mDone <= 1'b0; mGen <= 0; mCycle <= 0;
        end else if (mActive) begin
            if (abort) begin
                mActive <= 1'b0; mDone <= 1'b1;
                mGen    <= mCycle / GL + ((mCycle % GL == GL - 1) ? 1 : 0);
            end else if ((mCycle % GL == GL - 1) && (mCycle / GL + 1 == mTarget)) begin
                mActive <= 1'b0; mDone <= 1'b1; mGen <= mTarget;
            end else begin
                mCycle <= mCycle + 1;
            end
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (start) begin
            mGen    <= 0;
            mCycle  <= 0;
            mTarget <= int'(genCount);
            mActive <= (genCount != '0);
            mDone   <= (genCount == '0);
        end
    end

    int ePhase, eGen, eRdAddr, eWrAddr;
    bit eClr, eRd, eWr, eStream;
    logic [HEIGHT-1:0] eDin;
    always_comb begin
        ePhase  = mCycle % GL;
        eGen    = mActive ? mCycle / GL : mGen;
        eClr    = mActive && ePhase == 0;
        eRd     = mActive && ePhase < WIDTH;
        eWr     = mActive && ePhase >= 3;
        eStream = mActive && ePhase >= 1 && ePhase <= WIDTH;
        eRdAddr = ePhase;
        eWrAddr = ePhase - 3;
        eDin    = eStream ? memRdData : '0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the timeline model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("gen_done_cnt", 32'(genDoneCnt), eGen);
            checkOutput("bank_clr", 32'(bankClr), 32'(eClr));
            checkOutput("rd_en", 32'(memRdEn), 32'(eRd));
            checkOutput("wr_en", 32'(memWrEn), 32'(eWr));
            checkOutput("bank_din", 32'(bankDin), 32'(eDin));
            if (eRd) checkOutput("rd_addr", 32'(memRdAddr), eRdAddr);
            if (eWr) begin
                checkOutput("wr_addr", 32'(memWrAddr), eWrAddr);
                checkOutput("wr_data", 32'(memWrData), 32'(bankNext));
            end
        end
    end

    // 2D zero-padded Game of Life reference.
    logic [HEIGHT-1:0] refFrame [WIDTH];

    task automatic stepRef();
        logic [HEIGHT-1:0] nxt [WIDTH];
        for (int c = 0; c < WIDTH; c++) begin
            for (int r = 0; r < HEIGHT; r++) begin
                int n;
                n = 0;
                for (int dc = -1; dc <= 1; dc++)
                    for (int dr = -1; dr <= 1; dr++)
                        if (!(dc == 0 && dr == 0) && c + dc >= 0 && c + dc < WIDTH &&
                            r + dr >= 0 && r + dr < HEIGHT)
                            n += int'(refFrame[c+dc][r+dr]);
                nxt[c][r] = refFrame[c][r] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        for (int c = 0; c < WIDTH; c++) refFrame[c] = nxt[c];
    endtask

    task automatic loadFrame();
        for (int c = 0; c < WIDTH; c++) mem[c] = refFrame[c];
    endtask

    task automatic clearRef();
        for (int c = 0; c < WIDTH; c++) refFrame[c] = '0;
    endtask

    task automatic compareFrame(input string tag);
        for (int c = 0; c < WIDTH; c++)
            checkOutput($sformatf("%s_col%0d", tag, c), 32'(mem[c]), 32'(refFrame[c]));
    endtask

    int runDoneCycle, doneCount, rdCount, wrCount, genAtDone;
    int clrQ[$];

    // Starts a run at cycle 0 and observes until two cycles after done.
    task automatic applyStimulus(input int gc, input int abortAt, input int restartAt);
        runDoneCycle = -1; doneCount = 0; rdCount = 0; wrCount = 0; genAtDone = -1;
        clrQ.delete();
        @(negedge clk);
        start = 1'b1; genCount = GEN_W'(gc);
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            start = (c == restartAt);
            if (c == restartAt) genCount = GEN_W'(9);
            abort = (c == abortAt);
            if (bankClr) clrQ.push_back(c);
            if (memRdEn) rdCount++;
            if (memWrEn) wrCount++;
            if (done) begin
                doneCount++;
                if (runDoneCycle < 0) begin
                    runDoneCycle = c;
                    genAtDone = int'(genDoneCnt);
                end
            end
            if (runDoneCycle >= 0 && c >= runDoneCycle + 2) break;
        end
        start = 1'b0; abort = 1'b0;
        checkOutput("done_pulses", doneCount, 1);
    endtask

    logic [HEIGHT-1:0] expCols [WIDTH];
    int idleStrobes;

    initial begin
        rstN = 1'b0; start = 1'b1; genCount = GEN_W'(5); abort = 1'b0;
        for (int c = 0; c < WIDTH; c++) mem[c] = '0;

        // Reset held with start asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_gen", 32'(genDoneCnt), 0);
        checkOutput("rst_rd_en", 32'(memRdEn), 0);
        checkOutput("rst_rd_addr", 32'(memRdAddr), 0);
        checkOutput("rst_wr_en", 32'(memWrEn), 0);
        checkOutput("rst_wr_addr", 32'(memWrAddr), 0);
        checkOutput("rst_clr", 32'(bankClr), 0);
        checkOutput("rst_din", 32'(bankDin), 0);
        checkEn = 1'b1;
        rstN = 1'b1; start = 1'b0;
        idleStrobes = 0;
        repeat (10) begin
            @(negedge clk);
            if (memRdEn || memWrEn || bankClr || busy || done) idleStrobes++;
        end
        checkOutput("idle_strobes", idleStrobes, 0);

        // Zero generations: immediate done, no memory traffic.
        applyStimulus(0, -1, -1);
        checkOutput("gen0_done_cycle", runDoneCycle, 1);
        checkOutput("gen0_rd", rdCount, 0);
        checkOutput("gen0_wr", wrCount, 0);
        checkOutput("gen0_cnt", genAtDone, 0);

        // Blinker, one generation: also pins the basic timing.
        clearRef(); refFrame[2] = 8'b00001110; loadFrame();
        applyStimulus(1, -1, -1);
        checkOutput("g1_done_cycle", runDoneCycle, 12);
        checkOutput("g1_clr_count", clrQ.size(), 1);
        if (clrQ.size() > 0) checkOutput("g1_clr_cycle", clrQ[0], 1);
        checkOutput("g1_rd_count", rdCount, 8);
        checkOutput("g1_wr_count", wrCount, 8);
        checkOutput("g1_cnt", genAtDone, 1);
        for (int c = 0; c < WIDTH; c++) expCols[c] = '0;
        expCols[1] = 8'b00000100; expCols[2] = 8'b00000100; expCols[3] = 8'b00000100;
        for (int c = 0; c < WIDTH; c++)
            checkOutput($sformatf("blinker1_col%0d", c), 32'(mem[c]), 32'(expCols[c]));
        stepRef();
        compareFrame("blinker1_ref");

        // Blinker, two generations: original frame restored.
        clearRef(); refFrame[2] = 8'b00001110; loadFrame();
        applyStimulus(2, -1, -1);
        checkOutput("g2_done_cycle", runDoneCycle, 23);
        checkOutput("g2_cnt", genAtDone, 2);
        for (int c = 0; c < WIDTH; c++) expCols[c] = '0;
        expCols[2] = 8'b00001110;
        for (int c = 0; c < WIDTH; c++)
            checkOutput($sformatf("blinker2_col%0d", c), 32'(mem[c]), 32'(expCols[c]));

        // Glider on column 0, blinker on column 7; a start mid-run must be ignored.
        clearRef();
        refFrame[0] = 8'b00000100; refFrame[1] = 8'b00000101; refFrame[2] = 8'b00000110;
        refFrame[7] = 8'b11100000;
        loadFrame();
        applyStimulus(3, -1, 5);
        checkOutput("g3_done_cycle", runDoneCycle, 34);
        checkOutput("g3_cnt", genAtDone, 3);
        checkOutput("g3_clr_pulses", clrQ.size(), 3);
        if (clrQ.size() == 3) begin
            checkOutput("g3_clr_gap1", clrQ[1] - clrQ[0], 11);
            checkOutput("g3_clr_gap2", clrQ[2] - clrQ[1], 11);
        end
        repeat (3) stepRef();
        compareFrame("glider");

        // Abort at cycle 6 of generation 2 of a five-generation run.
        clearRef(); refFrame[2] = 8'b00001110; loadFrame();
        applyStimulus(5, 18, -1);
        checkOutput("abort_done_cycle", runDoneCycle, 19);
        checkOutput("abort_cnt", genAtDone, 1);
        checkOutput("abort_rd_count", rdCount, 15);
        checkOutput("abort_wr_count", wrCount, 12);

        // Reset in the middle of streaming.
        @(negedge clk);
        start = 1'b1; genCount = GEN_W'(2);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_rd_en", 32'(memRdEn), 0);
        checkOutput("midrst_wr_en", 32'(memWrEn), 0);
        checkOutput("midrst_clr", 32'(bankClr), 0);
        checkOutput("midrst_din", 32'(bankDin), 0);
        checkOutput("midrst_gen", 32'(genDoneCnt), 0);
        rstN = 1'b1;
        idleStrobes = 0;
        repeat (5) begin
            @(negedge clk);
            if (memRdEn || memWrEn || bankClr || busy || done) idleStrobes++;
        end
        checkOutput("midrst_idle_strobes", idleStrobes, 0);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
